// File: rtl/sram_write_sequencer_if.sv
// Write-request handshake plus array-side controls between a requester and sram_write_sequencer.
// drv_data is a real voltage level that feeds the analog write_driver.
interface sram_write_sequencer_if #(
    parameter int ADDR_W = 3
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_W-1:0]      wr_addr;
    logic                   wr_data;
    logic                   pre_en;
    logic                   drv_en;
    real                    drv_data;
    logic [2**ADDR_W-1:0]   wl_sel;
    logic                   wr_done;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, pre_en, drv_en, drv_data, wl_sel, wr_done
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, pre_en, drv_en, drv_data, wl_sel, wr_done
    );
endinterface

// File: rtl/sram_write_sequencer.sv
// Runs a single SRAM write (precharge, setup, word-line pulse, hold, done), one write in flight.
// wr_done follows accept by PRE_CYC+WL_CYC+2 edges; requests are ignored, not queued, while busy.
module sram_write_sequencer #(
    parameter int  ADDR_W  = 3,
    parameter int  PRE_CYC = 2,
    parameter int  WL_CYC  = 3,
    parameter real VDD     = 1.5,
    parameter real VSS     = 0.0
) (
    input  logic                      clk,
    input  logic                      rst,
    sram_write_sequencer_if.slave     bus
);
    localparam int DEPTH   = 2**ADDR_W;
    localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SETUP, S_WL, S_HOLD, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                bit_q, bit_d;
    logic                ready_q, ready_d;
    logic                pre_en_q, pre_en_d;
    logic                drv_en_q, drv_en_d;
    logic                lvl_q, lvl_d;
    logic [DEPTH-1:0]    wl_sel_q, wl_sel_d;
    logic                done_q, done_d;
    logic                adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_W'(1);
            addr_q  <= '0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            bit_q   <= bit_d;
        end
    end

    // Every state dwells until its counter reads 1; single-cycle states simply load 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        bit_d   = bit_q;
        adv     = (cnt_q == CNT_W'(1));
        case (state_q)
            S_IDLE: begin
                if (bus.wr_valid && ready_q) begin
                    state_d = S_PRE;
                    addr_d  = bus.wr_addr;
                    bit_d   = bus.wr_data;
                end
            end
            S_PRE:   if (adv) state_d = S_SETUP;
            S_SETUP: if (adv) state_d = S_WL;
            S_WL:    if (adv) state_d = S_HOLD;
            S_HOLD:  if (adv) state_d = S_DONE;
            S_DONE:  if (adv) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            case (state_d)
                S_PRE:   cnt_d = CNT_W'(PRE_CYC);
                S_WL:    cnt_d = CNT_W'(WL_CYC);
                default: cnt_d = CNT_W'(1);
            endcase
        end else if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        ready_d  = 1'b0;
        pre_en_d = 1'b0;
        drv_en_d = 1'b0;
        lvl_d    = 1'b0;
        wl_sel_d = '0;
        done_d   = 1'b0;
        case (state_d)
            S_IDLE: begin
                ready_d  = 1'b1;
                pre_en_d = 1'b1;
            end
            S_PRE:   pre_en_d = 1'b1;
            S_SETUP, S_HOLD: begin
                drv_en_d = 1'b1;
                lvl_d    = bit_d;
            end
            S_WL: begin
                drv_en_d         = 1'b1;
                lvl_d            = bit_d;
                wl_sel_d[addr_d] = 1'b1;
            end
            S_DONE: begin
                pre_en_d = 1'b1;
                done_d   = 1'b1;
            end
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b1;
            pre_en_q <= 1'b1;
            drv_en_q <= 1'b0;
            lvl_q    <= 1'b0;
            wl_sel_q <= '0;
            done_q   <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            pre_en_q <= pre_en_d;
            drv_en_q <= drv_en_d;
            lvl_q    <= lvl_d;
            wl_sel_q <= wl_sel_d;
            done_q   <= done_d;
        end
    end

    assign bus.wr_ready = ready_q;
    assign bus.pre_en   = pre_en_q;
    assign bus.drv_en   = drv_en_q;
    assign bus.drv_data = lvl_q ? VDD : VSS;
    assign bus.wl_sel   = wl_sel_q;
    assign bus.wr_done  = done_q;
endmodule
